adder_la_sequencer: RTL and testbench



---
 rtl/adder_la_pkg.sv | 29 ++
 rtl/adder_la_stats.sv | 51 +++++
 rtl/adder_la_sequencer.sv | 153 +++++++++++++++
 tb/tb_adder_la_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_la_pkg.sv
// Shared types and helpers for the adder logic-analyser sequencer.
package adder_la_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_CAPTURE,
    ST_CHECK,
    ST_FINISH
  } state_e;

  // Bit positions inside the la1 control word seen by the adder wrapper.
  localparam int CTRL_RUN = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_EXT = 2;

  localparam logic [31:0] DEF_LFSR_TAPS = 32'h80200003;

  // One Galois step. Operands are zero-extended to 64 bits so any width up to
  // 64 shifts correctly; callers truncate the result back to their width.
  function automatic logic [63:0] lfsr_step(input logic [63:0] x,
                                            input logic [63:0] taps);
    return x[0] ? ((x >> 1) ^ taps) : (x >> 1);
  endfunction

endpackage

// File: rtl/adder_la_stats.sv
// Batch statistics: last/min/max ring count and a saturating error counter.
module adder_la_stats #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             upd_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic             err_inc_i,
  output logic [15:0]      err_count_o,
  output logic [WIDTH-1:0] last_count_o,
  output logic [WIDTH-1:0] min_count_o,
  output logic [WIDTH-1:0] max_count_o
);

  logic [15:0]      err_q;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;

  // Clear on batch start, fold in each captured count, count mismatches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q  <= '0;
      last_q <= '0;
      min_q  <= '1;
      max_q  <= '0;
    end else begin
      if (clr_i) begin
        err_q <= '0;
        min_q <= '1;
        max_q <= '0;
      end
      if (upd_i) begin
        last_q <= count_i;
        if (count_i < min_q) min_q <= count_i;
        if (count_i > max_q) max_q <= count_i;
      end
      if (err_inc_i && (err_q != 16'hFFFF)) begin
        err_q <= err_q + 16'd1;
      end
    end
  end

  assign err_count_o  = err_q;
  assign last_count_o = last_q;
  assign min_count_o  = min_q;
  assign max_count_o  = max_q;

endmodule

// File: rtl/adder_la_sequencer.sv
// Drives the instrumented adder over its LA buses: generates operands, gates
// the ring run window, captures count/sum and checks the sum against a+b.
module adder_la_sequencer
  import adder_la_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter int               RUN_CYCLES    = 16,
  parameter int               SETTLE_CYCLES = 2,
  parameter logic [WIDTH-1:0] LFSR_TAPS     = WIDTH'(DEF_LFSR_TAPS)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [15:0]      num_tests,
  input  logic [WIDTH-1:0] seed,
  output logic             busy,
  output logic             done,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] last_count,
  output logic [WIDTH-1:0] min_count,
  output logic [WIDTH-1:0] max_count,
  output logic [WIDTH-1:0] la_ctrl,
  output logic [WIDTH-1:0] la_a,
  output logic [WIDTH-1:0] la_b,
  input  logic [WIDTH-1:0] la_count,
  input  logic [WIDTH-1:0] la_sum
);

  // The extended-ring select bit (CTRL_EXT) is never driven, so it stays 0.
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0] RUN_WORD = ONE_W << CTRL_RUN;
  localparam logic [WIDTH-1:0] CLR_WORD = ONE_W << CTRL_CLR;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] ctrl_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [15:0]      rem_q;
  logic [15:0]      tmr_q;
  logic [WIDTH-1:0] sum_q;

  logic [WIDTH-1:0] lfsr_s1;
  logic [WIDTH-1:0] lfsr_s2;
  logic [WIDTH-1:0] ref_sum;
  logic             stat_clr;
  logic             stat_upd;
  logic             err_inc;

  // Two LFSR steps per test: one for operand b, one to advance past it.
  always_comb begin
    lfsr_s1  = WIDTH'(lfsr_step(64'(lfsr_q), 64'(LFSR_TAPS)));
    lfsr_s2  = WIDTH'(lfsr_step(64'(lfsr_s1), 64'(LFSR_TAPS)));
    ref_sum  = a_q + b_q;
    stat_clr = (state_q == ST_IDLE) && start;
    stat_upd = (state_q == ST_CAPTURE);
    err_inc  = (state_q == ST_CHECK) && (sum_q != ref_sum);
  end

  // Batch sequencer; every output is registered on the state transition.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lfsr_q  <= ONE_W;
      rem_q   <= '0;
      tmr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            rem_q   <= num_tests;
            lfsr_q  <= (seed == '0) ? ONE_W : seed;
            state_q <= (num_tests == 16'd0) ? ST_FINISH : ST_LOAD;
          end
        end
        ST_LOAD: begin
          a_q     <= lfsr_q;
          b_q     <= lfsr_s1;
          lfsr_q  <= lfsr_s2;
          ctrl_q  <= CLR_WORD;
          state_q <= ST_CLEAR;
        end
        ST_CLEAR: begin
          ctrl_q  <= RUN_WORD;
          tmr_q   <= 16'(RUN_CYCLES);
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (tmr_q == 16'd1) begin
            ctrl_q  <= '0;
            tmr_q   <= 16'(SETTLE_CYCLES);
            state_q <= ST_SETTLE;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        ST_SETTLE: begin
          if (tmr_q == 16'd1) begin
            state_q <= ST_CAPTURE;
          end else begin
            tmr_q <= tmr_q - 16'd1;
          end
        end
        ST_CAPTURE: begin
          sum_q   <= la_sum;
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          rem_q   <= rem_q - 16'd1;
          state_q <= (rem_q == 16'd1) ? ST_FINISH : ST_LOAD;
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          ctrl_q  <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  adder_la_stats #(
    .WIDTH(WIDTH)
  ) u_stats (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .clr_i       (stat_clr),
    .upd_i       (stat_upd),
    .count_i     (la_count),
    .err_inc_i   (err_inc),
    .err_count_o (err_count),
    .last_count_o(last_count),
    .min_count_o (min_count),
    .max_count_o (max_count)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign la_ctrl = ctrl_q;
  assign la_a    = a_q;
  assign la_b    = b_q;

endmodule

// File: tb/tb_adder_la_sequencer.sv
// Bench for adder_la_sequencer with a behavioural adder model on the LA buses.
module tb_adder_la_sequencer;

  localparam int W = 32;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   num_tests;
  logic [W-1:0]  seed;
  logic [W-1:0]  la_count;
  logic [W-1:0]  la_sum;
  logic          busy;
  logic          done;
  logic [15:0]   err_count;
  logic [W-1:0]  last_count;
  logic [W-1:0]  min_count;
  logic [W-1:0]  max_count;
  logic [W-1:0]  la_ctrl;
  logic [W-1:0]  la_a;
  logic [W-1:0]  la_b;

  always #5 clk = ~clk;

  adder_la_sequencer dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .start     (start),
    .num_tests (num_tests),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .err_count (err_count),
    .last_count(last_count),
    .min_count (min_count),
    .max_count (max_count),
    .la_ctrl   (la_ctrl),
    .la_a      (la_a),
    .la_b      (la_b),
    .la_count  (la_count),
    .la_sum    (la_sum)
  );

  typedef struct {
    string           name;
    logic [15:0]     num;
    logic [31:0]     seed;
    logic [7:0][15:0] cnts;
    logic [7:0]      bad;
    bit              poke;
    logic [15:0]     e_err;
    logic [31:0]     e_last;
    logic [31:0]     e_min;
    logic [31:0]     e_max;
  } vec_t;

  typedef struct { logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct {
    logic [15:0] err; logic [31:0] last; logic [31:0] mn; logic [31:0] mx;
    int lat; int runs;
  } res_t;

  op_t  op_q[$];
  res_t res_q[$];
  vec_t vecs[4];

  int n_run  = 0;
  int n_fail = 0;

  // Adder model state: counts per test, indexed by how many clear pulses seen.
  int               clr_seen;
  logic [7:0][15:0] m_cnts;
  logic [7:0]       m_bad;
  logic             corrupt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] step(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (la_ctrl[1]) begin
      la_count = {16'd0, m_cnts[clr_seen[2:0]]};
      corrupt  = m_bad[clr_seen[2:0]];
      clr_seen++;
    end
    la_sum = (la_a + la_b) ^ {31'd0, corrupt};
  endtask

  task automatic run_batch(input vec_t v);
    logic [31:0] x;
    res_t r;
    op_t  o;
    int   cyc, runs, ext_bad;
    bit   got_done;
    clr_seen = 0;
    m_cnts   = v.cnts;
    m_bad    = v.bad;
    corrupt  = 1'b0;
    op_q.delete();
    x = (v.seed == 32'd0) ? 32'd1 : v.seed;
    for (int i = 0; i < int'(v.num); i++) begin
      o.a = x; x = step(x);
      o.b = x; x = step(x);
      op_q.push_back(o);
    end
    r.err = v.e_err; r.last = v.e_last; r.mn = v.e_min; r.mx = v.e_max;
    r.lat = 2 + 22 * int'(v.num);
    r.runs = 16 * int'(v.num);
    res_q.push_back(r);

    num_tests = v.num;
    seed      = v.seed;
    start     = 1'b1;
    cyc = 0; runs = 0; ext_bad = 0; got_done = 1'b0;
    while (!got_done && cyc < 22 * int'(v.num) + 40) begin
      tick();
      cyc++;
      start = 1'b0;
      if (v.poke && cyc == 10) begin
        start     = 1'b1;
        num_tests = 16'd3;
        seed      = 32'h00000007;
      end
      if (la_ctrl[0]) runs++;
      if (la_ctrl[W-1:2] != '0) ext_bad++;
      if (la_ctrl[1]) begin
        if (op_q.size() == 0) begin
          chk({v.name, "_extra_test"}, 64'd1, 64'd0);
        end else begin
          o = op_q.pop_front();
          chk({v.name, "_la_a"}, 64'(la_a), 64'(o.a));
          chk({v.name, "_la_b"}, 64'(la_b), 64'(o.b));
        end
      end
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    r = res_q.pop_front();
    chk({v.name, "_done_seen"}, 64'(got_done), 64'd1);
    chk({v.name, "_latency"}, 64'(cyc), 64'(r.lat));
    chk({v.name, "_run_cycles"}, 64'(runs), 64'(r.runs));
    chk({v.name, "_ctrl_hi_bits"}, 64'(ext_bad), 64'd0);
    chk({v.name, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({v.name, "_tests_left"}, 64'(op_q.size()), 64'd0);
    chk({v.name, "_err_count"}, 64'(err_count), 64'(r.err));
    chk({v.name, "_last_count"}, 64'(last_count), 64'(r.last));
    chk({v.name, "_min_count"}, 64'(min_count), 64'(r.mn));
    chk({v.name, "_max_count"}, 64'(max_count), 64'(r.mx));
    tick();
    chk({v.name, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int dn;
    bit seen_run;
    vecs[0] = '{"single", 16'd1, 32'd1,
                {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd100},
                8'h00, 1'b0, 16'd0, 32'd100, 32'd100, 32'd100};
    vecs[1] = '{"minmax", 16'd4, 32'hDEADBEEF,
                {16'd0, 16'd0, 16'd0, 16'd0, 16'd90, 16'd30, 16'd70, 16'd50},
                8'h00, 1'b1, 16'd0, 32'd90, 32'd30, 32'd90};
    // Seed 0 runs as seed 1; tests 2 and 3 get a corrupted sum.
    vecs[2] = '{"errors", 16'd5, 32'd0,
                {16'd0, 16'd0, 16'd0, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10},
                8'b0000_0110, 1'b0, 16'd2, 32'd50, 32'd10, 32'd50};
    // Empty batch: last_count keeps the previous batch's value.
    vecs[3] = '{"empty", 16'd0, 32'd5,
                {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0},
                8'h00, 1'b0, 16'd0, 32'd50, 32'hFFFFFFFF, 32'd0};

    rst = 1'b1; start = 1'b0; num_tests = '0; seed = '0;
    la_count = '0; la_sum = '0;
    clr_seen = 0; m_cnts = '0; m_bad = '0; corrupt = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_la_ctrl", 64'(la_ctrl), 64'd0);
    end
    chk("rst_min", 64'(min_count), 64'hFFFFFFFF);
    chk("rst_max", 64'(max_count), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_last", 64'(last_count), 64'd0);

    for (int i = 0; i < 4; i++) run_batch(vecs[i]);

    // Abort a batch with reset partway through the second test's run window.
    clr_seen = 0; m_cnts = {8{16'd60}}; m_bad = '0;
    num_tests = 16'd3; seed = 32'd1; start = 1'b1;
    seen_run = 1'b0;
    for (int i = 0; i < 100 && !seen_run; i++) begin
      tick();
      start = 1'b0;
      if (clr_seen == 2 && la_ctrl[0]) seen_run = 1'b1;
    end
    chk("abort_reached_run2", 64'(seen_run), 64'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("abort_la_ctrl", 64'(la_ctrl), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_min", 64'(min_count), 64'hFFFFFFFF);
    chk("abort_err", 64'(err_count), 64'd0);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || la_ctrl != '0 || busy) dn++;
    end
    chk("abort_quiet", 64'(dn), 64'd0);

    run_batch(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
